can_stuff_tx: RTL and testbench
===============================

# can_stuff_tx

Transmit-side CAN bit stuffer and bit-time serializer. It accepts one logical frame bit at a time from the frame builder over a valid/ready handshake and drives each bit on the serial line for CLKS_PER_BIT clocks. While stuffing is enabled, it inserts a complemented stuff bit after every run of five identical bits. It sits between the CAN TX frame builder and the transceiver pin, and produces exactly the bit stream the receive-side destuffer strips.

## Interface
- CLKS_PER_BIT, 10, clocks per nominal bit time; legal range ≥1.
- i_Clock  in  1  system clock; all logic on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Bit_Valid  in  1  upstream has a frame bit on i_Bit.
- i_Bit  in  1  frame bit (0 = dominant, 1 = recessive).
- i_Stuff_En  in  1  stuffing region flag (SOF through CRC sequence); sampled together with i_Bit on acceptance.
- o_Bit_Ready  out  1  block accepts i_Bit this cycle.
- o_Tx_Serial  out  1  serial line; idles recessive (1).
- o_Bit_Strobe  out  1  one-cycle pulse on the first clock of every transmitted bit, data or stuff.
- o_Stuff_Active  out  1  high for the whole bit time of an inserted stuff bit.
- o_Run_Count  out  3  length of the current run of identical bits (0..5).

## Operation
- FSM states are IDLE, DATA and STUFF.
- Bit timer counts 0..CLKS_PER_BIT-1 in DATA and STUFF. "Last cycle" means timer = CLKS_PER_BIT-1.
- o_Bit_Ready = !i_Reset && (IDLE || (last cycle && !stuff_pending)).
- A transfer occurs when i_Bit_Valid && o_Bit_Ready. The block latches the bit and its stuff flag, enters DATA, and resets the timer.
- At last cycle with no transfer and no stuff pending, the FSM goes to IDLE. o_Tx_Serial returns to 1.
- Run tracking is updated when a bit starts:
  - Data bit with stuff flag 0: run = 0.
  - Otherwise, if bit == last_bit and run ≠ 0: run + 1. Else run = 1.
  - last_bit takes the new value.
- stuff_pending is set when a data bit with stuff flag 1 brings run to 5.
- At the last cycle of that bit, the FSM enters STUFF regardless of i_Bit_Valid. It drives ~last_bit, sets run = 1 and last_bit = ~last_bit, and clears stuff_pending.
- The stuff bit counts as the first bit of the next run. Stuff bits never trigger further stuffing on their own.
- Stuff after the final stuffed-region bit (e.g. last CRC bit) is still inserted.
- A data bit accepted during the last cycle of STUFF follows with zero gap.
- Reset mid-operation aborts immediately. Any pending stuff bit is discarded.

## Timing
- Reset values:
  - o_Tx_Serial = 1
  - o_Bit_Strobe = 0
  - o_Stuff_Active = 0
  - o_Run_Count = 0
  - o_Bit_Ready = 0 while i_Reset is high
  - state = IDLE, timer = 0, last_bit = 1
- Latency: transfer at cycle t puts the bit on o_Tx_Serial at t+1, with o_Bit_Strobe at t+1. The bit is held through t+CLKS_PER_BIT.
- With i_Bit_Valid held high, strobes occur exactly every CLKS_PER_BIT cycles. A stuff bit adds exactly one bit time.
- o_Run_Count updates on the same cycle as o_Bit_Strobe.
- All outputs except o_Bit_Ready are registered.
- CLKS_PER_BIT = 1: every cycle is a last cycle. o_Bit_Ready is low only while a stuff bit is pending.

## Structure
- Shared package can_pkg holds:
  - CAN_DOMINANT = 0, CAN_RECESSIVE = 1
  - CAN_STUFF_RUN = 5
  - the tx_stuff_state_t enum (IDLE/DATA/STUFF), shared with the destuffer's constants.
- Sub-module can_bit_timer holds the bit-time counter and produces start and last-cycle pulses. It is parameterized by CLKS_PER_BIT and is reusable by the receive path.

## Test plan
- Reset, no valid: o_Tx_Serial = 1 and o_Bit_Ready = 1 from the first post-reset cycle. No strobes for 100 cycles.
- Five 0s with stuff flag 1, valid always high: serial 0,0,0,0,0,1. o_Stuff_Active is high for cycles 51–60. o_Bit_Ready is low at the 5th bit's last cycle. o_Run_Count reads 1,2,3,4,5,1.
- Bits 00000 then 1111, stuff flag 1: serial is 0000011111 followed by a 0 stuff bit, because the stuff 1 counts toward the 1-run. The trailing stuff bit is emitted even with valid low.
- Eight 0s with stuff flag 0: no stuff bit, 80 bit-clock cycles, o_Run_Count = 0 throughout.
- Alternating 0101010101, stuff flag 1: no stuff bits. Strobes every 10 cycles, run stays 1.
- Reset asserted at cycle 3 of a stuff bit: o_Tx_Serial = 1 the next cycle, o_Stuff_Active = 0, run = 0. The next accepted 0 is not stuffed until five 0s have followed.

Source files
------------

// File: rtl/can_pkg.sv
// Constants and types shared by the CAN bit stuffer (TX) and destuffer (RX).
package can_pkg;

  localparam logic       CAN_DOMINANT  = 1'b0;
  localparam logic       CAN_RECESSIVE = 1'b1;
  localparam logic [2:0] CAN_STUFF_RUN = 3'd5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_DATA  = 2'd1,
    TX_STUFF = 2'd2
  } tx_stuff_state_t;

  // Run length after a data bit starts. A bit outside the stuffing region clears the run.
  function automatic logic [2:0] can_next_run(
    input logic       bit_i,
    input logic       last_bit_i,
    input logic [2:0] run_i,
    input logic       stuff_en_i
  );
    logic [2:0] run_o;
    if (!stuff_en_i) begin
      run_o = 3'd0;
    end else if ((bit_i == last_bit_i) && (run_i != 3'd0)) begin
      run_o = run_i + 3'd1;
    end else begin
      run_o = 3'd1;
    end
    return run_o;
  endfunction

endpackage

// File: rtl/can_bit_timer.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while enabled, flags the first and last clock of a bit.
module can_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  input  logic enable_i,
  output logic start_o,
  output logic last_o
);

  localparam int                CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (restart_i || !enable_i || (count_q == CNT_MAX)) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign start_o = enable_i && (count_q == '0);
  assign last_o  = enable_i && (count_q == CNT_MAX);

endmodule

// File: rtl/can_stuff_tx.sv
// CAN TX bit stuffer and serializer: holds each frame bit for one bit time and inserts
// a complemented stuff bit after five identical bits inside the stuffing region.
//
// state    | meaning
// TX_IDLE  | line recessive, ready for the first bit
// TX_DATA  | driving a frame bit for one bit time
// TX_STUFF | driving an inserted stuff bit for one bit time
module can_stuff_tx
  import can_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Bit_Valid,
  input  logic       i_Bit,
  input  logic       i_Stuff_En,
  output logic       o_Bit_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Bit_Strobe,
  output logic       o_Stuff_Active,
  output logic [2:0] o_Run_Count
);

  tx_stuff_state_t state_q, state_d;

  logic       last_bit_q, last_bit_d;
  logic [2:0] run_q, run_d;
  logic       stuff_pending_q, stuff_pending_d;
  logic       tx_q, tx_d;
  logic       strobe_q, strobe_d;
  logic       stuff_active_q, stuff_active_d;

  logic       timer_active;
  logic       timer_start;
  logic       timer_last;
  logic       bit_ready;
  logic       xfer;
  logic       enter_stuff;
  logic [2:0] run_next;

  assign timer_active = (state_q != TX_IDLE);
  assign bit_ready    = !i_Reset && ((state_q == TX_IDLE) || (timer_last && !stuff_pending_q));
  assign xfer         = i_Bit_Valid && bit_ready;
  // A pending stuff bit takes the slot unconditionally; upstream is held off by bit_ready.
  assign enter_stuff  = (state_q == TX_DATA) && timer_last && stuff_pending_q;
  assign run_next     = can_next_run(i_Bit, last_bit_q, run_q, i_Stuff_En);

  can_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i    (i_Clock),
    .rst_i    (i_Reset),
    .restart_i(xfer || enter_stuff),
    .enable_i (timer_active),
    .start_o  (timer_start),
    .last_o   (timer_last)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TX_IDLE: begin
        if (xfer) begin
          state_d = TX_DATA;
        end
      end
      TX_DATA, TX_STUFF: begin
        if (timer_last) begin
          if (enter_stuff) begin
            state_d = TX_STUFF;
          end else if (xfer) begin
            state_d = TX_DATA;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    last_bit_d      = last_bit_q;
    run_d           = run_q;
    stuff_pending_d = stuff_pending_q;
    tx_d            = tx_q;
    strobe_d        = 1'b0;
    stuff_active_d  = stuff_active_q;
    if (xfer) begin
      tx_d            = i_Bit;
      strobe_d        = 1'b1;
      stuff_active_d  = 1'b0;
      run_d           = run_next;
      last_bit_d      = i_Bit;
      stuff_pending_d = i_Stuff_En && (run_next == CAN_STUFF_RUN);
    end else if (enter_stuff) begin
      // The stuff bit opens the next run, so it may itself start a new stuffable run.
      tx_d            = ~last_bit_q;
      strobe_d        = 1'b1;
      stuff_active_d  = 1'b1;
      run_d           = 3'd1;
      last_bit_d      = ~last_bit_q;
      stuff_pending_d = 1'b0;
    end else if (timer_last) begin
      tx_d            = CAN_RECESSIVE;
      stuff_active_d  = 1'b0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      last_bit_q      <= CAN_RECESSIVE;
      run_q           <= 3'd0;
      stuff_pending_q <= 1'b0;
      tx_q            <= CAN_RECESSIVE;
      strobe_q        <= 1'b0;
      stuff_active_q  <= 1'b0;
    end else begin
      last_bit_q      <= last_bit_d;
      run_q           <= run_d;
      stuff_pending_q <= stuff_pending_d;
      tx_q            <= tx_d;
      strobe_q        <= strobe_d;
      stuff_active_q  <= stuff_active_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      assert (timer_start == strobe_q);
    end
  end

  assign o_Bit_Ready    = bit_ready;
  assign o_Tx_Serial    = tx_q;
  assign o_Bit_Strobe   = strobe_q;
  assign o_Stuff_Active = stuff_active_q;
  assign o_Run_Count    = run_q;

endmodule

// File: tb/tb_can_stuff_tx.sv
// Self-checking bench for can_stuff_tx against a stream-level stuffing model.
module tb_can_stuff_tx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       flag = 1'b0;
  logic       ready;
  logic       tx;
  logic       strobe;
  logic       stuff_act;
  logic [2:0] run;

  can_stuff_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Bit_Valid   (valid),
    .i_Bit         (bit_in),
    .i_Stuff_En    (flag),
    .o_Bit_Ready   (ready),
    .o_Tx_Serial   (tx),
    .o_Bit_Strobe  (strobe),
    .o_Stuff_Active(stuff_act),
    .o_Run_Count   (run)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  bit         exp_tx[$];
  bit         exp_st[$];
  logic [2:0] exp_run[$];
  bit         obs_tx[$];
  bit         obs_st[$];
  logic [2:0] obs_run[$];
  int         obs_cyc[$];
  int         stuff_cyc[$];
  int         t_xfer[$];
  bit         d_bit[$];
  bit         d_flg[$];
  bit         m_reg[$];

  bit mon_en = 1'b0;
  bit held_tx, held_st;
  int since = CPB;

  always @(negedge clk) begin
    if (mon_en) begin
      if (strobe) begin
        obs_tx.push_back(tx);
        obs_st.push_back(stuff_act);
        obs_run.push_back(run);
        obs_cyc.push_back(cyc);
        held_tx = tx;
        held_st = stuff_act;
        since = 0;
      end else begin
        since++;
        if (since < CPB) begin
          checks++;
          if (tx !== held_tx || stuff_act !== held_st) begin
            errors++;
            $display("FAIL hold cyc %0d: tx %b stuff %b, required tx %b stuff %b",
                     cyc, tx, stuff_act, held_tx, held_st);
          end
        end
      end
      if (stuff_act) stuff_cyc.push_back(cyc);
    end
  end

  task automatic clear_obs();
    exp_tx.delete(); exp_st.delete(); exp_run.delete();
    obs_tx.delete(); obs_st.delete(); obs_run.delete();
    obs_cyc.delete(); stuff_cyc.delete(); t_xfer.delete();
    d_bit.delete(); d_flg.delete();
    since = CPB;
  endtask

  // Model: the stuffing region stream is what the line carried since the last unstuffed bit.
  function automatic int trailing_run();
    int n = 0;
    for (int i = m_reg.size() - 1; i >= 0; i--) begin
      if (m_reg[i] != m_reg[m_reg.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_reg.delete();
  endtask

  task automatic model_push(input bit b, input bit f);
    int tr;
    d_bit.push_back(b);
    d_flg.push_back(f);
    if (!f) begin
      m_reg.delete();
      exp_tx.push_back(b); exp_st.push_back(1'b0); exp_run.push_back(3'd0);
    end else begin
      m_reg.push_back(b);
      tr = trailing_run();
      exp_tx.push_back(b); exp_st.push_back(1'b0); exp_run.push_back(3'(tr));
      if (tr == 5) begin
        m_reg.push_back(!b);
        exp_tx.push_back(!b); exp_st.push_back(1'b1); exp_run.push_back(3'(trailing_run()));
      end
    end
  endtask

  task automatic drive_bits(input int gap_max);
    for (int i = 0; i < d_bit.size(); i++) begin
      int w;
      if (gap_max > 0) begin
        valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
      valid = 1'b1; bit_in = d_bit[i]; flag = d_flg[i];
      w = 0;
      #1;
      while (!ready && w < 200) begin
        @(negedge clk); #1; w++;
      end
      checks++;
      if (!ready) begin
        errors++;
        $display("FAIL accept bit %0d: ready %b after %0d cycles, required 1", i, ready, w);
      end
      t_xfer.push_back(cyc);
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  task automatic drain();
    repeat (2 * CPB + 5) @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; valid = 1'b0; mon_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: %b required 0", ready); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: %b required 1", tx); end
    checks++; if (strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: %b required 0", strobe); end
    checks++; if (stuff_act !== 1'b0) begin errors++; $display("FAIL rst_stuff: %b required 0", stuff_act); end
    checks++; if (run !== 3'd0) begin errors++; $display("FAIL rst_run: %0d required 0", run); end
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: %b required 1", ready); end
    clear_obs();
    mon_en = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    #2;
    checks++; if (obs_tx.size() != 0) begin errors++; $display("FAIL idle_strobes: %0d required 0", obs_tx.size()); end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_tx: %0d non-recessive cycles required 0", bad); end
  endtask

  task automatic test_five_zeros();
    int t0, k;
    clear_obs();
    for (int i = 0; i < 5; i++) model_push(1'b0, 1'b1);
    drive_bits(0);
    t0 = t_xfer[0];
    k = 0;
    while (cyc < t0 + 50 && k < 100) begin @(negedge clk); k++; end
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL five_ready_at_last: %b required 0", ready); end
    drain();
    checks++; if (obs_tx.size() != exp_tx.size()) begin errors++; $display("FAIL five_count: %0d bits required %0d", obs_tx.size(), exp_tx.size()); end
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i] || obs_st[i] !== exp_st[i] || obs_run[i] !== exp_run[i]) begin
        errors++;
        $display("FAIL five bit %0d: tx/stuff/run %b/%b/%0d required %b/%b/%0d", i, obs_tx[i], obs_st[i], obs_run[i], exp_tx[i], exp_st[i], exp_run[i]);
      end
    end
    checks++; if (obs_cyc.size() == 0 || obs_cyc[0] != t0 + 1) begin errors++; $display("FAIL five_latency: first strobe not at cycle %0d", t0 + 1); end
    checks++;
    if (stuff_cyc.size() != 10 || stuff_cyc[0] != t0 + 51 || stuff_cyc[stuff_cyc.size() - 1] != t0 + 60) begin
      errors++;
      $display("FAIL five_stuff_window: %0d cycles, required %0d..%0d", stuff_cyc.size(), t0 + 51, t0 + 60);
    end
    checks++; if (tx !== 1'b1 || ready !== 1'b1) begin errors++; $display("FAIL five_idle: tx %b ready %b required 1 1", tx, ready); end
  endtask

  task automatic test_run_carry();
    bit seq[9];
    seq = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    clear_obs();
    for (int i = 0; i < 9; i++) model_push(seq[i], 1'b1);
    drive_bits(0);
    drain();
    checks++; if (obs_tx.size() != exp_tx.size()) begin errors++; $display("FAIL carry_count: %0d bits required %0d", obs_tx.size(), exp_tx.size()); end
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i] || obs_st[i] !== exp_st[i] || obs_run[i] !== exp_run[i]) begin
        errors++;
        $display("FAIL carry bit %0d: tx/stuff/run %b/%b/%0d required %b/%b/%0d", i, obs_tx[i], obs_st[i], obs_run[i], exp_tx[i], exp_st[i], exp_run[i]);
      end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] - obs_cyc[i - 1] != CPB) begin errors++; $display("FAIL carry_spacing %0d: %0d required %0d", i, obs_cyc[i] - obs_cyc[i - 1], CPB); end
    end
  endtask

  task automatic test_no_stuff_region();
    clear_obs();
    for (int i = 0; i < 8; i++) model_push(1'b0, 1'b0);
    drive_bits(0);
    drain();
    checks++; if (obs_tx.size() != 8) begin errors++; $display("FAIL nostuff_count: %0d bits required 8", obs_tx.size()); end
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i] || obs_st[i] !== exp_st[i] || obs_run[i] !== exp_run[i]) begin
        errors++;
        $display("FAIL nostuff bit %0d: tx/stuff/run %b/%b/%0d required %b/%b/%0d", i, obs_tx[i], obs_st[i], obs_run[i], exp_tx[i], exp_st[i], exp_run[i]);
      end
    end
    checks++; if (obs_cyc.size() != 8 || obs_cyc[7] - obs_cyc[0] != 7 * CPB) begin errors++; $display("FAIL nostuff_span: strobes %0d not 70 cycles apart", obs_cyc.size()); end
    checks++; if (stuff_cyc.size() != 0) begin errors++; $display("FAIL nostuff_active: %0d cycles required 0", stuff_cyc.size()); end
  endtask

  task automatic test_alternating();
    clear_obs();
    for (int i = 0; i < 10; i++) model_push(1'(i % 2), 1'b1);
    drive_bits(0);
    drain();
    checks++; if (obs_tx.size() != exp_tx.size()) begin errors++; $display("FAIL alt_count: %0d bits required %0d", obs_tx.size(), exp_tx.size()); end
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i] || obs_st[i] !== exp_st[i] || obs_run[i] !== exp_run[i]) begin
        errors++;
        $display("FAIL alt bit %0d: tx/stuff/run %b/%b/%0d required %b/%b/%0d", i, obs_tx[i], obs_st[i], obs_run[i], exp_tx[i], exp_st[i], exp_run[i]);
      end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] - obs_cyc[i - 1] != CPB) begin errors++; $display("FAIL alt_spacing %0d: %0d required %0d", i, obs_cyc[i] - obs_cyc[i - 1], CPB); end
    end
  endtask

  task automatic test_reset_mid_stuff();
    int t0, k;
    clear_obs();
    mon_en = 1'b0;
    for (int i = 0; i < 5; i++) model_push(1'b0, 1'b1);
    drive_bits(0);
    t0 = t_xfer[0];
    k = 0;
    while (cyc < t0 + 53 && k < 100) begin @(negedge clk); k++; end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL abort_tx: %b required 1", tx); end
    checks++; if (stuff_act !== 1'b0) begin errors++; $display("FAIL abort_stuff: %b required 0", stuff_act); end
    checks++; if (run !== 3'd0) begin errors++; $display("FAIL abort_run: %0d required 0", run); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_ready: %b required 0", ready); end
    rst = 1'b0;
    model_reset();
    clear_obs();
    @(negedge clk);
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) model_push(1'b0, 1'b1);
    drive_bits(0);
    drain();
    checks++; if (obs_tx.size() != exp_tx.size()) begin errors++; $display("FAIL after_abort_count: %0d bits required %0d", obs_tx.size(), exp_tx.size()); end
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i] || obs_st[i] !== exp_st[i] || obs_run[i] !== exp_run[i]) begin
        errors++;
        $display("FAIL after_abort bit %0d: tx/stuff/run %b/%b/%0d required %b/%b/%0d", i, obs_tx[i], obs_st[i], obs_run[i], exp_tx[i], exp_st[i], exp_run[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      int n, k, gap;
      bit b;
      clear_obs();
      n = $urandom_range(20, 40);
      k = n - $urandom_range(0, 10);
      gap = (f == 0) ? 0 : 3;
      b = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 99) < 35) b = !b;
        model_push(b, i < k);
      end
      drive_bits(gap);
      drain();
      checks++; if (obs_tx.size() != exp_tx.size()) begin errors++; $display("FAIL rand%0d_count: %0d bits required %0d", f, obs_tx.size(), exp_tx.size()); end
      for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
        checks++;
        if (obs_tx[i] !== exp_tx[i] || obs_st[i] !== exp_st[i] || obs_run[i] !== exp_run[i]) begin
          errors++;
          $display("FAIL rand%0d bit %0d: tx/stuff/run %b/%b/%0d required %b/%b/%0d", f, i, obs_tx[i], obs_st[i], obs_run[i], exp_tx[i], exp_st[i], exp_run[i]);
        end
      end
      for (int i = 1; i < obs_cyc.size(); i++) begin
        checks++;
        if ((gap == 0 && obs_cyc[i] - obs_cyc[i - 1] != CPB) || obs_cyc[i] - obs_cyc[i - 1] < CPB) begin
          errors++;
          $display("FAIL rand%0d_spacing %0d: %0d cycles", f, i, obs_cyc[i] - obs_cyc[i - 1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_five_zeros();
    test_run_carry();
    test_no_stuff_region();
    test_alternating();
    test_reset_mid_stuff();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
